mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle main control FSM for the MIPS-lite core; it drives the 4-bit ALUOp consumed by the ALU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Decodes opcode/funct from the instruction register and produces per-state datapath enables and mux selects.
- Consumes the ALU Zero flag to resolve beq.

Parameters:
- PC_SRC_W, 2, width of PC source select.
- STATE_W, 3, width of state encoding and debug State port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Instr  in  32  current IR contents; [31:26] opcode, [5:0] funct.
- Zero  in  1  ALU Zero flag, valid in EXEC.
- ALUOp  out  4  0000 ADD, 0001 SUB, 0010 OR, 0011 LUI, 0100 SLL.
- ALUSrc  out  1  0 = register B, 1 = extended immediate.
- ExtOp  out  1  0 = zero-extend, 1 = sign-extend imm16.
- PC_En  out  1  PC load enable.
- PC_Src  out  PC_SRC_W  00 PC+4, 01 PC+(simm<<2), 10 {PC[31:28],imm26,00}, 11 rs.
- IR_En  out  1  IR load enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- WD_Sel  out  2  00 ALU result reg, 01 memory data reg, 10 PC (already +4).
- Illegal  out  1  unsupported instruction flag (see feature).
- State  out  STATE_W  current state, debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Only the state register is sequential; all outputs are combinational from state and Instr.
- While reset=1: state=FETCH. All enables (PC_En, IR_En, MemWrite, RegWrite) and Illegal are forced 0, and all selects are 0.
- The first FETCH executes on the first rising edge after reset deasserts.
- Reset mid-instruction aborts it with no further writes.
- Default in every state: enables 0, ALUOp=ADD, selects 0.
- Supported instructions: addu (R, funct 100001), subu (R, 100011), sll (R, 000000), jr (R, 001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), jal (000011).
- nop (0x00000000) is sll to $0 and takes the full 4-cycle path.
- FETCH: IR_En=1, PC_En=1, PC_Src=00. Next state DECODE.
- DECODE:
  - jal: RegWrite=1, RegDst=10, WD_Sel=10, PC_En=1, PC_Src=10; next FETCH. 2 cycles total.
  - jr: PC_En=1, PC_Src=11; next FETCH.
  - Other supported instructions: next EXEC.
- EXEC ALUOp:
  - addu: ADD.
  - subu: SUB.
  - sll: SLL.
  - ori: OR, ALUSrc=1, ExtOp=0.
  - lui: LUI, ALUSrc=1.
  - lw/sw: ADD, ALUSrc=1, ExtOp=1.
  - beq: SUB, ALUSrc=0.
- EXEC next state:
  - R-type/ori/lui: WB.
  - lw/sw: MEM.
  - beq: if Zero=1 then PC_En=1, PC_Src=01; next FETCH in both cases. 3 cycles total.
- MEM:
  - sw: MemWrite=1; next FETCH. 4 cycles total.
  - lw: next WB.
- WB: RegWrite=1.
  - R-type: RegDst=01, WD_Sel=00.
  - ori/lui: RegDst=00, WD_Sel=00.
  - lw: RegDst=00, WD_Sel=01.
  - Next FETCH.
- Latency per instruction: R/ori/lui 4 cycles, lw 5, sw 4, beq 3, jal/jr 2.
- Unused state codes 6/7 return to FETCH on the next edge with all outputs defaulted.

Optional Feature:
- Macro: MC_CONTROLLER_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode/funct in DECODE goes to HALT. In HALT, Illegal=1, all enables 0, and the FSM stays there until reset.
- Undefined: an unsupported instruction in DECODE is treated as nop and returns to FETCH with no writes. Illegal is tied 0 and HALT is unreachable.

Test Plan:
- Reset asserted mid-WB of addu (Instr=0x00221821) -> RegWrite drops to 0 immediately, State=0. After release the sequence is FETCH, DECODE, EXEC (ALUOp=0000), WB (RegWrite=1, RegDst=01).
- ori $1,$0,0x1234 (0x34011234) -> EXEC: ALUOp=0010, ALUSrc=1, ExtOp=0. WB: RegDst=00, WD_Sel=00. 4 cycles total.
- lw $2,-4($1) (0x8C22FFFC) -> EXEC ALUOp=0000, ExtOp=1, then MEM, then WB with WD_Sel=01; 5 cycles. sw (0xAC22FFFC) -> MemWrite=1 for exactly one cycle in MEM; 4 cycles.
- beq (0x10220003) with Zero=1 -> EXEC: ALUOp=0001, PC_En=1, PC_Src=01. With Zero=0 -> PC_En=0 in EXEC. Both cases take 3 cycles.
- jal 0x0C000010 -> DECODE: RegWrite=1, RegDst=10, WD_Sel=10, PC_Src=10. jr $31 (0x03E00008) -> DECODE: PC_Src=11. Each returns to FETCH next cycle.
- Instr=0xFC000000:
  - With the macro defined -> State=5 and Illegal=1 held for 10 cycles, with no enables.
  - Without it -> returns to FETCH after DECODE with Illegal=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle main control FSM for the MIPS-lite core: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define MC_CONTROLLER_ILLEGAL_TRAP_EN to trap unsupported instructions in HALT.
module mc_controller #(
    parameter int PC_SRC_W = 2,
    parameter int STATE_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Instr,
    input  logic                Zero,
    output logic [3:0]          ALUOp,
    output logic                ALUSrc,
    output logic                ExtOp,
    output logic                PC_En,
    output logic [PC_SRC_W-1:0] PC_Src,
    output logic                IR_En,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          WD_Sel,
    output logic                Illegal,
    output logic [STATE_W-1:0]  State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        EXEC   = STATE_W'(2),
        MEM    = STATE_W'(3),
        WB     = STATE_W'(4),
        HALT   = STATE_W'(5)
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    state_t state_q, state_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r, is_addu, is_subu, is_sll, is_jr;
    logic       is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic       is_supported;
    logic       unused_instr;

    assign opcode       = Instr[31:26];
    assign funct        = Instr[5:0];
    assign unused_instr = ^Instr[25:6];

    assign is_r    = (opcode == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_sll  = is_r && (funct == 6'b000000);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_ori  = (opcode == 6'b001101);
    assign is_lui  = (opcode == 6'b001111);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_jal  = (opcode == 6'b000011);

    assign is_supported = is_addu | is_subu | is_sll | is_jr | is_ori | is_lui |
                          is_lw | is_sw | is_beq | is_jal;

    logic [3:0]          alu_op_c;
    logic                alu_src_c, ext_op_c, pc_en_c, ir_en_c;
    logic                mem_write_c, reg_write_c, illegal_c;
    logic [PC_SRC_W-1:0] pc_src_c;
    logic [1:0]          reg_dst_c, wd_sel_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_op_c    = ALU_ADD;
        alu_src_c   = 1'b0;
        ext_op_c    = 1'b0;
        pc_en_c     = 1'b0;
        pc_src_c    = '0;
        ir_en_c     = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        reg_dst_c   = 2'b00;
        wd_sel_c    = 2'b00;
        illegal_c   = 1'b0;

        case (state_q)
            FETCH: begin
                ir_en_c  = 1'b1;
                pc_en_c  = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                if (is_jal) begin
                    // Link writes the already-incremented PC into $31 while jumping.
                    reg_write_c = 1'b1;
                    reg_dst_c   = 2'b10;
                    wd_sel_c    = 2'b10;
                    pc_en_c     = 1'b1;
                    pc_src_c    = PC_SRC_W'(2);
                    state_d     = FETCH;
                end else if (is_jr) begin
                    pc_en_c  = 1'b1;
                    pc_src_c = PC_SRC_W'(3);
                    state_d  = FETCH;
                end else if (is_supported) begin
                    state_d = EXEC;
                end else begin
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = FETCH;
`endif
                end
            end
            EXEC: begin
                state_d = FETCH;
                if (is_addu) begin
                    state_d = WB;
                end else if (is_subu) begin
                    alu_op_c = ALU_SUB;
                    state_d  = WB;
                end else if (is_sll) begin
                    alu_op_c = ALU_SLL;
                    state_d  = WB;
                end else if (is_ori) begin
                    alu_op_c  = ALU_OR;
                    alu_src_c = 1'b1;
                    state_d   = WB;
                end else if (is_lui) begin
                    alu_op_c  = ALU_LUI;
                    alu_src_c = 1'b1;
                    state_d   = WB;
                end else if (is_lw || is_sw) begin
                    alu_src_c = 1'b1;
                    ext_op_c  = 1'b1;
                    state_d   = MEM;
                end else if (is_beq) begin
                    alu_op_c = ALU_SUB;
                    if (Zero) begin
                        pc_en_c  = 1'b1;
                        pc_src_c = PC_SRC_W'(1);
                    end
                end
            end
            MEM: begin
                state_d = FETCH;
                if (is_sw) begin
                    mem_write_c = 1'b1;
                end else if (is_lw) begin
                    state_d = WB;
                end
            end
            WB: begin
                state_d = FETCH;
                if (is_addu || is_subu || is_sll) begin
                    reg_write_c = 1'b1;
                    reg_dst_c   = 2'b01;
                end else if (is_ori || is_lui) begin
                    reg_write_c = 1'b1;
                end else if (is_lw) begin
                    reg_write_c = 1'b1;
                    wd_sel_c    = 2'b01;
                end
            end
            HALT: begin
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
                illegal_c = 1'b1;
                state_d   = HALT;
`else
                state_d   = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    // Async reset must silence the datapath at once, even though FETCH would drive IR_En/PC_En.
    assign ALUOp    = reset ? ALU_ADD : alu_op_c;
    assign ALUSrc   = reset ? 1'b0    : alu_src_c;
    assign ExtOp    = reset ? 1'b0    : ext_op_c;
    assign PC_En    = reset ? 1'b0    : pc_en_c;
    assign PC_Src   = reset ? '0      : pc_src_c;
    assign IR_En    = reset ? 1'b0    : ir_en_c;
    assign MemWrite = reset ? 1'b0    : mem_write_c;
    assign RegWrite = reset ? 1'b0    : reg_write_c;
    assign RegDst   = reset ? 2'b00   : reg_dst_c;
    assign WD_Sel   = reset ? 2'b00   : wd_sel_c;
    assign Illegal  = reset ? 1'b0    : illegal_c;
    assign State    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-instruction expected output vectors, scoreboard queue, summary.
// Build with MC_CONTROLLER_ILLEGAL_TRAP_EN defined to exercise the HALT trap.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0;
  logic [3:0]  ALUOp;
  logic        ALUSrc, ExtOp, PC_En, IR_En, MemWrite, RegWrite, Illegal;
  logic [1:0]  PC_Src, RegDst, WD_Sel;
  logic [2:0]  State;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .PC_En(PC_En),
    .PC_Src(PC_Src), .IR_En(IR_En), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .WD_Sel(WD_Sel), .Illegal(Illegal), .State(State)
  );

  // Output vector layout: {State, ALUOp, ALUSrc, ExtOp, PC_En, PC_Src, IR_En,
  // MemWrite, RegWrite, RegDst, WD_Sel, Illegal}
  typedef struct {
    string           name;
    logic [31:0]     instr;
    logic            zero;
    int              n;
    logic [4:0][19:0] exp;
  } vec_t;

  logic [19:0] exp_q[$];
  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [19:0] v_fetch, v_dec, v_rst, v_wb_r, v_wb_i, v_wb_l, v_halt;

  function automatic logic [19:0] pk(int st, int alu, int src, int ext, int pce, int pcs,
                                     int ire, int mw, int rw, int rd, int wd, int ill);
    logic [31:0] s, a, p, r, w;
    s = st; a = alu; p = pcs; r = rd; w = wd;
    return {s[2:0], a[3:0], src[0], ext[0], pce[0], p[1:0], ire[0], mw[0], rw[0],
            r[1:0], w[1:0], ill[0]};
  endfunction

  function automatic logic [19:0] act_vec();
    return {State, ALUOp, ALUSrc, ExtOp, PC_En, PC_Src, IR_En, MemWrite, RegWrite,
            RegDst, WD_Sel, Illegal};
  endfunction

  function automatic vec_t mk(string name, logic [31:0] instr, logic zero, int n,
                              logic [19:0] e1, logic [19:0] e2, logic [19:0] e3,
                              logic [19:0] e4);
    vec_t v;
    v.name = name; v.instr = instr; v.zero = zero; v.n = n;
    v.exp[0] = v_fetch; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  task automatic check_now(string name, int cyc);
    logic [19:0] e, a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc %0d scoreboard empty", name, cyc);
      return;
    end
    e = exp_q.pop_front();
    a = act_vec();
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d got %05h exp %05h (state got %0d exp %0d)",
               name, cyc, a, e, a[19:17], e[19:17]);
    end
  endtask

  // Enters at posedge+1 with the FSM in FETCH; leaves at posedge+1 after n cycles.
  task automatic run_instr(vec_t v);
    Instr = v.instr;
    Zero  = v.zero;
    for (int c = 0; c < v.n; c++) exp_q.push_back(v.exp[c]);
    for (int c = 0; c < v.n; c++) begin
      @(negedge clk);
      check_now(v.name, c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    exp_q.push_back(v_rst);
    check_now("reset_pulse", 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [19:0] ex_ls;
    vec_t part;
    vec_t ill;

    v_fetch = pk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    v_dec   = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_rst   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_wb_r  = pk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    v_wb_i  = pk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    v_wb_l  = pk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v_halt  = pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ex_ls   = pk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = mk("addu", 32'h00221821, 1'b0, 4, v_dec, pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_r, '0);
    vecs[1]  = mk("subu", 32'h00221823, 1'b0, 4, v_dec, pk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_r, '0);
    vecs[2]  = mk("sll",  32'h00011080, 1'b0, 4, v_dec, pk(2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_r, '0);
    vecs[3]  = mk("nop",  32'h00000000, 1'b1, 4, v_dec, pk(2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_r, '0);
    vecs[4]  = mk("ori",  32'h34011234, 1'b0, 4, v_dec, pk(2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_i, '0);
    vecs[5]  = mk("lui",  32'h3C011234, 1'b0, 4, v_dec, pk(2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_i, '0);
    vecs[6]  = mk("lw",   32'h8C22FFFC, 1'b0, 5, v_dec, ex_ls, pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), v_wb_l);
    vecs[7]  = mk("sw",   32'hAC22FFFC, 1'b0, 4, v_dec, ex_ls, pk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), '0);
    vecs[8]  = mk("beq_taken", 32'h10220003, 1'b1, 3, v_dec, pk(2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), '0, '0);
    vecs[9]  = mk("beq_not",   32'h10220003, 1'b0, 3, v_dec, pk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '0, '0);
    vecs[10] = mk("jal",  32'h0C000010, 1'b0, 2, pk(1, 0, 0, 0, 1, 2, 0, 0, 1, 2, 2, 0), '0, '0, '0);
    vecs[11] = mk("jr",   32'h03E00008, 1'b0, 2, pk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0), '0, '0, '0);

    // Outputs held quiet while reset is asserted from time zero.
    #2;
    exp_q.push_back(v_rst);
    check_now("reset_state", 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_instr(vecs[i]);

    // Reset during WB of addu: write enable must drop before the next edge.
    part = vecs[0];
    part.n = 3;
    part.name = "addu_to_wb";
    run_instr(part);
    exp_q.push_back(v_wb_r);
    @(negedge clk);
    check_now("addu_wb_before_reset", 0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(v_rst);
    check_now("reset_mid_wb", 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(vecs[0]);

    // Unsupported opcode.
    ill = mk("illegal", 32'hFC000000, 1'b0, 2, v_dec, '0, '0, '0);
    run_instr(ill);
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      exp_q.push_back(v_halt);
      @(negedge clk);
      check_now("halt_hold", c);
      @(posedge clk);
      #1;
    end
    pulse_reset();
`endif
    // Unsupported funct (slt) behaves like the unsupported opcode.
    ill = mk("illegal_funct", 32'h0022182A, 1'b0, 2, v_dec, '0, '0, '0);
    run_instr(ill);
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    exp_q.push_back(v_halt);
    @(negedge clk);
    check_now("halt_funct", 0);
    pulse_reset();
`endif
    run_instr(vecs[0]);

    // Random back-to-back instruction mix.
    for (int k = 0; k < 40; k++) run_instr(vecs[$urandom_range(0, 11)]);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
